// File: rtl/rotate_unit_if.sv
// Rotate unit bus: start/done/busy handshake with the control unit plus the
// single read port and single write port of the 25x64 lane state file.
//   start   : level request into the rotate unit
//   done    : step complete, held until reset
//   busy    : step in progress (RUN or DRAIN)
//   rd_addr : lane being read (combinational read by the state file)
//   rd_data : lane value at rd_addr, valid in the same cycle
//   wr_en   : state-file write strobe, write lands on the next rising edge
//   wr_addr : lane being written
//   wr_data : rotated lane value
interface rotate_unit_if;
    localparam int unsigned LANE_W = 64;
    localparam int unsigned ADDR_W = 5;

    logic              start;
    logic              done;
    logic              busy;
    logic [ADDR_W-1:0] rd_addr;
    logic [LANE_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [LANE_W-1:0] wr_data;

    // Rotate unit side
    modport slave (
        input  start,
        input  rd_data,
        output done,
        output busy,
        output rd_addr,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    // Control unit / state file side
    modport master (
        output start,
        output rd_data,
        input  done,
        input  busy,
        input  rd_addr,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/rotate_unit.sv
// Keccak rho step: streams lanes 0..24 out of the state file, rotates each
// left by its fixed offset and writes it back one cycle later.
//   clock : single clock, rising edge
//   reset : synchronous active-high, aborts any step in progress
//   bus   : rotate_unit_if.slave (handshake + state-file read/write ports)
module rotate_unit (
    input  logic         clock,
    input  logic         reset,
    rotate_unit_if.slave bus
);
    localparam int unsigned LANE_W   = 64;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned ROT_W    = 6;
    localparam logic [ADDR_W-1:0] LAST_LANE = ADDR_W'(24);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   cnt, cnt_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [LANE_W-1:0]   wr_data_q, wr_data_d;

    // Rho rotation offsets indexed by lane x + 5*y
    function automatic logic [ROT_W-1:0] rho_offset(input logic [ADDR_W-1:0] lane);
        unique case (lane)
            5'd0:  rho_offset = 6'd0;
            5'd1:  rho_offset = 6'd1;
            5'd2:  rho_offset = 6'd62;
            5'd3:  rho_offset = 6'd28;
            5'd4:  rho_offset = 6'd27;
            5'd5:  rho_offset = 6'd36;
            5'd6:  rho_offset = 6'd44;
            5'd7:  rho_offset = 6'd6;
            5'd8:  rho_offset = 6'd55;
            5'd9:  rho_offset = 6'd20;
            5'd10: rho_offset = 6'd3;
            5'd11: rho_offset = 6'd10;
            5'd12: rho_offset = 6'd43;
            5'd13: rho_offset = 6'd25;
            5'd14: rho_offset = 6'd39;
            5'd15: rho_offset = 6'd41;
            5'd16: rho_offset = 6'd45;
            5'd17: rho_offset = 6'd15;
            5'd18: rho_offset = 6'd21;
            5'd19: rho_offset = 6'd8;
            5'd20: rho_offset = 6'd18;
            5'd21: rho_offset = 6'd2;
            5'd22: rho_offset = 6'd61;
            5'd23: rho_offset = 6'd56;
            5'd24: rho_offset = 6'd14;
            default: rho_offset = 6'd0;
        endcase
    endfunction

    // Circular left rotate; a zero offset shifts the right half out entirely
    function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] x,
                                               input logic [ROT_W-1:0]  r);
        rotl = (x << r) | (x >> (7'd64 - 7'(r)));
    endfunction

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        done_d    = done_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt;
                wr_data_d = rotl(bus.rd_data, rho_offset(cnt));
                // cnt parks at 0 after the last lane so rd_addr reads 0 outside RUN
                if (cnt == LAST_LANE) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + ADDR_W'(1);
                end
            end
            DRAIN: begin
                state_d = DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // cnt is zero in every state but RUN, so it serves directly as the read address
    assign bus.rd_addr = cnt;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_rotate_unit.sv
// Directed bench for rotate_unit: behavioural 25x64 state file with a
// combinational read port, write monitor, and one task per scenario.
module tb_rotate_unit;
    logic clock;
    logic reset;

    rotate_unit_if bus ();

    rotate_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Rho offsets, transcribed from the algorithm definition
    int rho [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                     41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    // State file model
    logic [63:0] mem      [25];
    logic [63:0] init_mem [25];
    logic        load;

    assign bus.rd_data = (bus.rd_addr < 5'd25) ? mem[bus.rd_addr] : 64'hDEAD_BEEF_DEAD_BEEF;

    always @(posedge clock) begin
        if (load) begin
            for (int i = 0; i < 25; i++) mem[i] <= init_mem[i];
        end else if (bus.wr_en && bus.wr_addr < 5'd25) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Write-port monitor
    logic mon_clr;
    int   wr_cnt;
    int   addr_err;
    int   overlap_err;

    always @(posedge clock) begin
        if (mon_clr) begin
            wr_cnt      <= 0;
            addr_err    <= 0;
            overlap_err <= 0;
        end else if (bus.wr_en) begin
            if (bus.wr_addr != 5'(wr_cnt)) addr_err <= addr_err + 1;
            if (bus.rd_addr == bus.wr_addr) overlap_err <= overlap_err + 1;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic load_lanes(input logic [63:0] v [25]);
        init_mem = v;
        load = 1'b1;
        @(posedge clock); #1;
        load = 1'b0;
    endtask

    // Starts a step; returns cycles from the start edge to done, or -1 on timeout
    task automatic run_step(input bit pulse, output int lat);
        start_and_clear();
        @(posedge clock); #1;
        mon_clr = 1'b0;
        if (pulse) bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 60) begin
            @(posedge clock); #1;
            lat++;
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic start_and_clear();
        bus.start = 1'b1;
        mon_clr   = 1'b1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", bus.wr_en); end
        checks++; if (bus.rd_addr !== 5'd0) begin errors++; $display("FAIL reset_rd_addr got %0d exp 0", bus.rd_addr); end
        checks++; if (bus.wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr got %0d exp 0", bus.wr_addr); end
        checks++; if (bus.wr_data !== 64'd0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", bus.wr_data); end
        reset = 1'b0;
    endtask

    task automatic test_vector();
        logic [63:0] v [25];
        int lat;
        do_reset();
        for (int i = 0; i < 25; i++) v[i] = 64'd0;
        v[0]  = 64'h0123456789ABCDEF;
        v[1]  = 64'h1;
        v[2]  = 64'h4;
        v[24] = 64'h8000000000000000;
        load_lanes(v);
        run_step(1'b1, lat);
        checks++; if (lat !== 26) begin errors++; $display("FAIL vec_latency got %0d exp 26", lat); end
        checks++; if (mem[0] !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL vec_lane0 got %h exp 0123456789abcdef", mem[0]); end
        checks++; if (mem[1] !== 64'h2) begin errors++; $display("FAIL vec_lane1 got %h exp 2", mem[1]); end
        checks++; if (mem[2] !== 64'h1) begin errors++; $display("FAIL vec_lane2 got %h exp 1", mem[2]); end
        checks++; if (mem[24] !== 64'h0000000000002000) begin errors++; $display("FAIL vec_lane24 got %h exp 2000", mem[24]); end
        checks++; if (mem[3] !== 64'h0) begin errors++; $display("FAIL vec_lane3 got %h exp 0", mem[3]); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL vec_busy_after got %b exp 0", bus.busy); end
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL vec_wr_en_after got %b exp 0", bus.wr_en); end
    endtask

    task automatic test_all_ones();
        logic [63:0] v [25];
        int lat;
        do_reset();
        for (int i = 0; i < 25; i++) v[i] = '1;
        load_lanes(v);
        run_step(1'b1, lat);
        checks++; if (lat !== 26) begin errors++; $display("FAIL ones_latency got %0d exp 26", lat); end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (mem[i] !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL ones_lane%0d got %h exp ffffffffffffffff", i, mem[i]); end
        end
        checks++; if (wr_cnt !== 25) begin errors++; $display("FAIL ones_wr_count got %0d exp 25", wr_cnt); end
        checks++; if (addr_err !== 0) begin errors++; $display("FAIL ones_wr_order got %0d bad addrs exp 0", addr_err); end
        checks++; if (overlap_err !== 0) begin errors++; $display("FAIL ones_rd_wr_overlap got %0d exp 0", overlap_err); end
    endtask

    task automatic test_single_bits();
        logic [63:0] v [25];
        logic [63:0] exp;
        int lat;
        do_reset();
        for (int i = 0; i < 25; i++) v[i] = 64'h1;
        load_lanes(v);
        run_step(1'b1, lat);
        checks++; if (lat !== 26) begin errors++; $display("FAIL bits_latency got %0d exp 26", lat); end
        for (int i = 0; i < 25; i++) begin
            exp = 64'h1 << rho[i];
            checks++;
            if (mem[i] !== exp) begin errors++; $display("FAIL bits_lane%0d got %h exp %h", i, mem[i], exp); end
        end
        checks++; if (mem[12] !== 64'h0000080000000000) begin errors++; $display("FAIL bits_lane12_const got %h exp 0000080000000000", mem[12]); end
    endtask

    task automatic test_hold_start();
        logic [63:0] v [25];
        logic [63:0] exp;
        int lat;
        do_reset();
        for (int i = 0; i < 25; i++) v[i] = 64'h1;
        load_lanes(v);
        run_step(1'b0, lat);
        checks++; if (lat !== 26) begin errors++; $display("FAIL hold_latency got %0d exp 26", lat); end
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL hold_wr_en cyc %0d got %b exp 0", c, bus.wr_en); end
            checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL hold_done cyc %0d got %b exp 1", c, bus.done); end
        end
        bus.start = 1'b0;
        checks++; if (wr_cnt !== 25) begin errors++; $display("FAIL hold_wr_count got %0d exp 25", wr_cnt); end
        for (int i = 0; i < 25; i++) begin
            exp = 64'h1 << rho[i];
            checks++;
            if (mem[i] !== exp) begin errors++; $display("FAIL hold_lane%0d got %h exp %h", i, mem[i], exp); end
        end
    endtask

    task automatic test_reset_abort();
        logic [63:0] v [25];
        logic [63:0] exp;
        int lat;
        do_reset();
        for (int i = 0; i < 25; i++) v[i] = 64'h1;
        load_lanes(v);
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        // Reset sampled on the edge that would open the 10th write cycle
        reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL abort_wr_en got %b exp 0", bus.wr_en); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
        for (int i = 0; i < 25; i++) begin
            exp = (i < 9) ? (64'h1 << rho[i]) : 64'h1;
            checks++;
            if (mem[i] !== exp) begin errors++; $display("FAIL abort_lane%0d got %h exp %h", i, mem[i], exp); end
        end
        // Start on the very first edge with reset low
        reset = 1'b0;
        run_step(1'b1, lat);
        checks++; if (lat !== 26) begin errors++; $display("FAIL abort_rerun_latency got %0d exp 26", lat); end
        checks++; if (wr_cnt !== 25) begin errors++; $display("FAIL abort_rerun_wr_count got %0d exp 25", wr_cnt); end
        for (int i = 0; i < 25; i++) begin
            exp = (i < 9) ? (64'h1 << ((2 * rho[i]) % 64)) : (64'h1 << rho[i]);
            checks++;
            if (mem[i] !== exp) begin errors++; $display("FAIL abort_rerun_lane%0d got %h exp %h", i, mem[i], exp); end
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        load      = 1'b0;
        mon_clr   = 1'b1;
        for (int i = 0; i < 25; i++) init_mem[i] = 64'd0;
        @(posedge clock); #1;
        test_reset();
        test_vector();
        test_all_ones();
        test_single_bits();
        test_hold_start();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
